// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Elapsed-time datapath for the stopwatch. A prescaler divides the system
// clock down to one centisecond step while `run` is high; each step advances
// a BCD count of minutes, seconds and centiseconds (0:00.00 .. 9:59.99).
// The count freezes while `run` is low, keeping any partial prescaler
// interval so that pausing does not lose time.
//
// Parameters:
//   TICK_DIV  clock cycles per centisecond (>= 2)
//   PRE_W     prescaler width, 2**PRE_W >= TICK_DIV
//
// Ports:
//   clock  in   system clock, rising-edge active
//   reset  in   asynchronous active-high reset, clears all state
//   run    in   1 = counting, 0 = paused (already synchronous to clock)
//   clear  in   synchronous zero of count, prescaler, tick and ovf
//   cs_u   out  centiseconds units, BCD 0-9
//   cs_t   out  centiseconds tens, BCD 0-9
//   s_u    out  seconds units, BCD 0-9
//   s_t    out  seconds tens, BCD 0-5
//   min    out  minutes, BCD 0-9
//   tick   out  one-cycle pulse in the cycle after the count advances
//   ovf    out  sticky flag, set when the count wraps 9:59.99 -> 0:00.00
// -----------------------------------------------------------------------------
module stopwatch_counter #(
  parameter int TICK_DIV = 1000000,
  parameter int PRE_W    = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       clear,
  output logic [3:0] cs_u,
  output logic [3:0] cs_t,
  output logic [3:0] s_u,
  output logic [2:0] s_t,
  output logic [3:0] min,
  output logic       tick,
  output logic       ovf
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_cs_u;
  logic [3:0]       r_cs_t;
  logic [3:0]       r_s_u;
  logic [2:0]       r_s_t;
  logic [3:0]       r_min;
  logic             r_tick;
  logic             r_ovf;

  logic             w_tc;
  logic [PRE_W-1:0] w_pre_nxt;
  logic             w_c_cs_t;
  logic             w_c_s_u;
  logic             w_c_s_t;
  logic             w_c_min;
  logic             w_wrap;
  logic [3:0]       w_cs_u_nxt;
  logic [3:0]       w_cs_t_nxt;
  logic [3:0]       w_s_u_nxt;
  logic [2:0]       w_s_t_nxt;
  logic [3:0]       w_min_nxt;

  // Prescaler: counts only while run is high, so a paused partial interval
  // is kept; the terminal count is the centisecond increment strobe.
  always_comb begin
    w_tc      = 1'b0;
    w_pre_nxt = r_pre;
    if (run) begin
      if (r_pre == PRE_LAST) begin
        w_tc      = 1'b1;
        w_pre_nxt = PRE_ZERO;
      end else begin
        w_pre_nxt = r_pre + PRE_ONE;
      end
    end else begin
      w_pre_nxt = r_pre;
    end
  end

  // Carry chain: every digit's carry-in is resolved in the same cycle, so a
  // multi-digit rollover (e.g. 0:59.99 -> 1:00.00) lands on one edge.
  always_comb begin
    w_c_cs_t = w_tc     && (r_cs_u == 4'd9);
    w_c_s_u  = w_c_cs_t && (r_cs_t == 4'd9);
    w_c_s_t  = w_c_s_u  && (r_s_u  == 4'd9);
    w_c_min  = w_c_s_t  && (r_s_t  == 3'd5);
    w_wrap   = w_c_min  && (r_min  == 4'd9);
  end

  // Next digit values: a digit with carry-in either rolls to 0 at its
  // maximum or increments; otherwise it holds.
  always_comb begin
    w_cs_u_nxt = r_cs_u;
    w_cs_t_nxt = r_cs_t;
    w_s_u_nxt  = r_s_u;
    w_s_t_nxt  = r_s_t;
    w_min_nxt  = r_min;
    if (w_tc) begin
      w_cs_u_nxt = w_c_cs_t ? 4'd0 : (r_cs_u + 4'd1);
    end else begin
      w_cs_u_nxt = r_cs_u;
    end
    if (w_c_cs_t) begin
      w_cs_t_nxt = w_c_s_u ? 4'd0 : (r_cs_t + 4'd1);
    end else begin
      w_cs_t_nxt = r_cs_t;
    end
    if (w_c_s_u) begin
      w_s_u_nxt = w_c_s_t ? 4'd0 : (r_s_u + 4'd1);
    end else begin
      w_s_u_nxt = r_s_u;
    end
    if (w_c_s_t) begin
      w_s_t_nxt = w_c_min ? 3'd0 : (r_s_t + 3'd1);
    end else begin
      w_s_t_nxt = r_s_t;
    end
    if (w_c_min) begin
      w_min_nxt = w_wrap ? 4'd0 : (r_min + 4'd1);
    end else begin
      w_min_nxt = r_min;
    end
  end

  // State registers: clear outranks a coincident terminal count, which is
  // discarded along with the pending tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre  <= PRE_ZERO;
      r_cs_u <= 4'd0;
      r_cs_t <= 4'd0;
      r_s_u  <= 4'd0;
      r_s_t  <= 3'd0;
      r_min  <= 4'd0;
      r_tick <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (clear) begin
      r_pre  <= PRE_ZERO;
      r_cs_u <= 4'd0;
      r_cs_t <= 4'd0;
      r_s_u  <= 4'd0;
      r_s_t  <= 3'd0;
      r_min  <= 4'd0;
      r_tick <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_pre  <= w_pre_nxt;
      r_cs_u <= w_cs_u_nxt;
      r_cs_t <= w_cs_t_nxt;
      r_s_u  <= w_s_u_nxt;
      r_s_t  <= w_s_t_nxt;
      r_min  <= w_min_nxt;
      r_tick <= w_tc;
      r_ovf  <= r_ovf | w_wrap;
    end
  end

  assign cs_u = r_cs_u;
  assign cs_t = r_cs_t;
  assign s_u  = r_s_u;
  assign s_t  = r_s_t;
  assign min  = r_min;
  assign tick = r_tick;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
//
// Self-checking bench. Main instance (TICK_DIV=4) covers reset, basic count,
// pause retention, clear priority, carry chain and randomized run/clear.
// A second instance (TICK_DIV=2) on a faster clock runs in parallel to reach
// the 9:59.99 wrap and exercise the sticky ovf flag. The reference model
// keeps elapsed time as a plain integer number of centiseconds and derives
// the display digits arithmetically.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

  typedef struct {
    int   cnt;
    int   pre;
    logic ovf;
    logic tick;
  } model_t;

  logic clock = 1'b0;
  logic clk_f = 1'b0;
  always #5 clock = ~clock;
  always #1 clk_f = ~clk_f;

  // main instance
  logic reset, run, clear;
  logic [3:0] m_cs_u, m_cs_t, m_s_u, m_min;
  logic [2:0] m_s_t;
  logic m_tick, m_ovf;

  // wrap instance
  logic rst_f, run_f, clear_f;
  logic [3:0] f_cs_u, f_cs_t, f_s_u, f_min;
  logic [2:0] f_s_t;
  logic f_tick, f_ovf;

  stopwatch_counter #(.TICK_DIV(4), .PRE_W(3)) dut (
    .clock(clock), .reset(reset), .run(run), .clear(clear),
    .cs_u(m_cs_u), .cs_t(m_cs_t), .s_u(m_s_u), .s_t(m_s_t), .min(m_min),
    .tick(m_tick), .ovf(m_ovf)
  );

  stopwatch_counter #(.TICK_DIV(2), .PRE_W(1)) dut_wrap (
    .clock(clk_f), .reset(rst_f), .run(run_f), .clear(clear_f),
    .cs_u(f_cs_u), .cs_t(f_cs_t), .s_u(f_s_u), .s_t(f_s_t), .min(f_min),
    .tick(f_tick), .ovf(f_ovf)
  );

  // Digits packed as {min, s_t, s_u, cs_t, cs_u}, so 0:59.99 reads 19'h05999.
  wire logic [18:0] dig_m = {m_min, m_s_t, m_s_u, m_cs_t, m_cs_u};
  wire logic [18:0] dig_f = {f_min, f_s_t, f_s_u, f_cs_t, f_cs_u};

  int n_chk;
  int n_fail;
  model_t mm;
  model_t wm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Display digits for an elapsed time given in centiseconds.
  function automatic logic [18:0] digits_of(input int c);
    int sec;
    sec = (c / 100) % 60;
    return {4'((c / 6000) % 10), 3'(sec / 10), 4'(sec % 10),
            4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  // One clock of the reference behaviour.
  function automatic model_t step(input model_t m, input int td, input logic r, input logic c);
    model_t n;
    n = m;
    n.tick = 1'b0;
    if (c) begin
      n.cnt = 0;
      n.pre = 0;
      n.ovf = 1'b0;
    end else if (r) begin
      if (m.pre == td - 1) begin
        n.pre  = 0;
        n.tick = 1'b1;
        if (m.cnt == 59999) begin
          n.cnt = 0;
          n.ovf = 1'b1;
        end else begin
          n.cnt = m.cnt + 1;
        end
      end else begin
        n.pre = m.pre + 1;
      end
    end
    return n;
  endfunction

  function automatic model_t zero_model();
    model_t z;
    z.cnt = 0; z.pre = 0; z.ovf = 1'b0; z.tick = 1'b0;
    return z;
  endfunction

  // Main instance: drive at negedge, step model at posedge, compare at negedge.
  task automatic cyc(input logic r, input logic c);
    run   = r;
    clear = c;
    @(posedge clock);
    mm = step(mm, 4, r, c);
    @(negedge clock);
    chk("digits", dig_m, digits_of(mm.cnt));
    chk("tick", m_tick, mm.tick);
    chk("ovf", m_ovf, mm.ovf);
    chk("st_range", (m_s_t <= 3'd5), 1);
  endtask

  task automatic wait_tick(input int lim, output int k);
    k = lim + 1;
    for (int i = 1; i <= lim; i++) begin
      cyc(1'b1, 1'b0);
      if (m_tick) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wcyc(input logic r, input logic c);
    run_f   = r;
    clear_f = c;
    @(posedge clk_f);
    wm = step(wm, 2, r, c);
    @(negedge clk_f);
    chk("w_digits", dig_f, digits_of(wm.cnt));
    chk("w_tick", f_tick, wm.tick);
    chk("w_ovf", f_ovf, wm.ovf);
  endtask

  task automatic main_seq();
    int ntk, last, k;
    mm = zero_model();
    repeat (2) @(negedge clock);
    chk("rst_digits", dig_m, 0);
    chk("rst_tick", m_tick, 0);
    chk("rst_ovf", m_ovf, 0);
    reset = 1'b0;

    // basic count: 40 cycles -> 10 ticks spaced 4 apart, 0:00.10
    ntk = 0; last = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 1'b0);
      if (m_tick) begin
        ntk++;
        chk("tick_space", i - last, 4);
        last = i;
      end
    end
    chk("basic_cs_t", m_cs_t, 1);
    chk("basic_cs_u", m_cs_u, 0);
    chk("basic_ticks", ntk, 10);

    // pause retention: 2 run cycles, 20 paused, resume -> increment after 2
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    ntk = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0);
      if (m_tick) ntk++;
    end
    chk("pause_ticks", ntk, 0);
    wait_tick(8, k);
    chk("resume_lat", k, 2);

    // clear coincident with terminal count
    cyc(1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("clr_tick", m_tick, 0);
    chk("clr_digits", dig_m, 0);
    wait_tick(8, k);
    chk("clr_lat", k, 4);

    // carry chain 0:59.99 -> 1:00.00 on one edge
    cyc(1'b0, 1'b1);
    repeat (5999 * 4) cyc(1'b1, 1'b0);
    chk("carry_pre", dig_m, 19'h05999);
    repeat (3) cyc(1'b1, 1'b0);
    chk("carry_hold", dig_m, 19'h05999);
    cyc(1'b1, 1'b0);
    chk("carry_post", dig_m, 19'h08000);

    // asynchronous reset mid-count at 0:03.47
    cyc(1'b0, 1'b1);
    repeat (347 * 4) cyc(1'b1, 1'b0);
    chk("at_0347", dig_m, 19'h00347);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    mm = zero_model();
    chk("async_rst_digits", dig_m, 0);
    chk("async_rst_tick", m_tick, 0);
    chk("async_rst_ovf", m_ovf, 0);
    @(posedge clock);
    @(negedge clock);
    chk("held_rst_digits", dig_m, 0);
    reset = 1'b0;
    wait_tick(8, k);
    chk("post_rst_lat", k, 4);

    // randomized run/clear against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic wrap_seq();
    wm = zero_model();
    repeat (2) @(negedge clk_f);
    rst_f = 1'b0;
    for (int i = 0; i < 120000; i++) begin
      wcyc(1'b1, 1'b0);
      if (i == 119998) begin
        chk("pre_wrap_digits", dig_f, 19'h4D999);
        chk("pre_wrap_ovf", f_ovf, 0);
      end
    end
    chk("wrap_digits", dig_f, 0);
    chk("wrap_ovf", f_ovf, 1);
    repeat (200) wcyc(1'b1, 1'b0);
    chk("ovf_sticky", f_ovf, 1);
    chk("post_wrap_digits", dig_f, 19'h00100);
    wcyc(1'b1, 1'b1);
    chk("clr_ovf", f_ovf, 0);
    chk("clr_wrap_digits", dig_f, 0);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    run     = 1'b0;
    clear   = 1'b0;
    rst_f   = 1'b1;
    run_f   = 1'b0;
    clear_f = 1'b0;
    fork
      main_seq();
      wrap_seq();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Timekeeping datapath that consumes the `run` level from the button control FSM and accumulates elapsed time as BCD digits (minutes, seconds, centiseconds) for the display driver. A parameterised prescaler derives one centisecond tick from the system clock while `run` is high. The count freezes while `run` is low. The count clears on reset or on a synchronous `clear`.

## Interface
- `TICK_DIV`, default 1000000: clock cycles per centisecond (100 MHz clock); legal range ≥ 2.
- `PRE_W`, default 20: prescaler width; must satisfy 2^PRE_W ≥ TICK_DIV.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `run`  in  1  level from the button control FSM; 1 = counting, 0 = paused.
- `clear`  in  1  synchronous zero of count, prescaler and `ovf`.
- `cs_u`  out  4  centiseconds units, BCD 0–9.
- `cs_t`  out  4  centiseconds tens, BCD 0–9.
- `s_u`  out  4  seconds units, BCD 0–9.
- `s_t`  out  3  seconds tens, BCD 0–5.
- `min`  out  4  minutes, BCD 0–9.
- `tick`  out  1  one-cycle pulse, asserted in the cycle after the count advances.
- `ovf`  out  1  sticky wrap flag.

## Operation
- **Prescaler `pre`** (PRE_W bits):
  - `run`=1 and `pre` = TICK_DIV−1: `pre` → 0 and a centisecond increment occurs.
  - `run`=1 otherwise: `pre` increments.
  - `run`=0: `pre` holds, so a partial interval is retained across a pause and is not discarded.
- **Increment cascade**, evaluated in a single cycle:
  - `cs_u` 9 → 0 carries into `cs_t`.
  - `cs_t` 9 → 0 carries into `s_u`.
  - `s_u` 9 → 0 carries into `s_t`.
  - `s_t` 5 → 0 carries into `min`.
  - `min` 9 → 0 is a full wrap to 0:00.00 and sets `ovf`.
- **`ovf`**:
  - Remains 1 until `reset` or `clear`.
  - Further wraps leave it at 1.
- **`clear`**:
  - Highest synchronous priority: zeroes all digits, `pre`, `tick` and `ovf` regardless of `run`.
  - A coincident prescaler terminal count is discarded.
- **Digit validity**: no digit ever holds a non-BCD value. Out-of-range values are unreachable and need not be handled.
- **No `run` sampling logic**: `run` is already synchronous to `clock`, being produced by the button control FSM on the same clock.

## Timing
- **Reset**:
  - All outputs are 0 while `reset`=1. `pre` = 0.
  - Reset asserted mid-count zeroes immediately (asynchronously).
  - Counting resumes on the first rising edge after deassertion at which `run`=1.
- **Latency**:
  - From `run` rising at edge E, the first increment occurs at edge E + TICK_DIV − 1 − `pre`(at E), and digits are visible after that edge.
  - Steady-state spacing between increments is exactly TICK_DIV cycles.
- **`tick`** is registered:
  - It is high for exactly the one cycle following each increment edge.
  - It is never high while paused, except for the cycle immediately after an increment that coincided with `run` falling.
- **Simultaneous events**:
  - `run` falling in the same cycle that `pre` = TICK_DIV−1: the increment still occurs (`run` was sampled high).
  - `clear` together with `run`=1: the result is zero and `pre` = 0, so the next increment is TICK_DIV cycles later.
- **Multi-level carry**: all digit changes appear on the same edge. For example, 0:59.99 → 1:00.00 occurs in one cycle with no intermediate values.

## Test plan
Use `TICK_DIV`=4 and `PRE_W`=3 for all scenarios.
- **Reset**: assert `reset` for 1 cycle mid-count at 0:03.47 → all digits, `tick` and `ovf` read 0 during reset; the first `tick` arrives 4 cycles after `run` is held high post-reset.
- **Basic count**: `run`=1 for 40 cycles from zero → `cs_t`=1, `cs_u`=0, with exactly 10 `tick` pulses spaced 4 cycles apart.
- **Pause retention**: `run`=1 for 2 cycles, 0 for 20, then 1 again → the first increment occurs 2 cycles after resuming and no `tick` fires during the pause.
- **Carry chain**: preload to 0:59.99 by running 5999 ticks, then run 4 more cycles → 1:00.00 on a single edge, and `s_t` never exceeds 5.
- **Wrap**: run to 9:59.99 plus one tick → all digits 0 and `ovf`=1; after another 100 ticks `ovf` is still 1; `clear` pulse → `ovf`=0 and digits 0.
- **Clear priority**: assert `clear` with `run`=1 on the terminal-count cycle → digits stay 0, no `tick` follows, and the next increment is 4 cycles later.
